kernel_nchan_vop_core: RTL

KERNEL_NCHAN_VOP_CORE -- requirements
Module: kernel_nchan_vop_core

---
 rtl/kernel_nchan_vop_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/kernel_nchan_vop_core.sv
// N-channel lane-wise vector add: joins C_NUM_CHANNELS AXI-Stream inputs, sums lanes,
// adds a latched constant (wrapping or unsigned-saturating) through a 2-stage pipeline.
module kernel_nchan_vop_core #(
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LANE_WIDTH      = 32,
    parameter int C_NUM_CHANNELS    = 2,
    parameter int C_XFER_SIZE_WIDTH = 32
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic                                     ctrl_start,
    output logic                                     ctrl_done,
    input  logic [C_XFER_SIZE_WIDTH-1:0]             ctrl_xfer_size_in_bytes,
    input  logic [C_LANE_WIDTH-1:0]                  ctrl_constant,
    input  logic                                     ctrl_mode,
    input  logic [C_NUM_CHANNELS-1:0]                s_tvalid,
    output logic [C_NUM_CHANNELS-1:0]                s_tready,
    input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]   s_tdata,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [C_DATA_WIDTH-1:0]                  m_tdata,
    output logic                                     m_tlast
);

    localparam int LANES      = C_DATA_WIDTH / C_LANE_WIDTH;
    localparam int SUM_W      = C_LANE_WIDTH + $clog2(C_NUM_CHANNELS) + 1;
    localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
    localparam int CNT_W      = C_XFER_SIZE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          in_rem_q, in_rem_d;
    logic [C_LANE_WIDTH-1:0]   const_q, const_d;
    logic                      mode_q, mode_d;
    logic                      done_q;

    logic [LANES*SUM_W-1:0]    s1_sum_q, s1_sum_d;
    logic                      s1_valid_q, s1_last_q;
    logic [C_DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic                      s2_valid_q, s2_last_q;
    logic [SUM_W-1:0]          lane_sum_s [LANES];

    logic                      adv_s;
    logic                      accept_s;
    logic                      out_last_hs_s;
    logic [CNT_W:0]            size_ext_s;
    logic [CNT_W:0]            beats_ext_s;

    // Widened ceiling division so a byte count near the top of the range cannot wrap.
    assign size_ext_s  = {1'b0, ctrl_xfer_size_in_bytes} + (CNT_W+1)'(BEAT_BYTES - 1);
    assign beats_ext_s = size_ext_s / (CNT_W+1)'(BEAT_BYTES);

    assign adv_s         = !s2_valid_q || m_tready;
    assign accept_s      = !areset && (state_q == S_RUN) && (in_rem_q != {CNT_W{1'b0}})
                           && (&s_tvalid) && adv_s;
    assign out_last_hs_s = s2_valid_q && m_tready && s2_last_q;

    assign s_tready  = {C_NUM_CHANNELS{accept_s}};
    assign m_tvalid  = s2_valid_q;
    assign m_tdata   = s2_data_q;
    assign m_tlast   = s2_valid_q && s2_last_q;
    assign ctrl_done = done_q;

    // Next-state logic: latches the job on start and tracks remaining input beats.
    always_comb begin
        state_d  = state_q;
        in_rem_d = in_rem_q;
        const_d  = const_q;
        mode_d   = mode_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_d  = S_RUN;
                    in_rem_d = beats_ext_s[CNT_W-1:0];
                    const_d  = ctrl_constant;
                    mode_d   = ctrl_mode;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (out_last_hs_s || (in_rem_q == {CNT_W{1'b0}})) begin
                    state_d = S_DONE;
                end else if (accept_s) begin
                    in_rem_d = in_rem_q - CNT_W'(1);
                    if (in_rem_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (out_last_hs_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; ctrl_done is registered off the next-state decode.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= S_IDLE;
            in_rem_q <= {CNT_W{1'b0}};
            const_q  <= {C_LANE_WIDTH{1'b0}};
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_rem_q <= in_rem_d;
            const_q  <= const_d;
            mode_q   <= mode_d;
            done_q   <= (state_d == S_DONE);
        end
    end

    // Stage-1 combinational: per-lane sum across all channels, widened so it never overflows.
    always_comb begin
        s1_sum_d = {(LANES*SUM_W){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < C_NUM_CHANNELS; c++) begin
                s1_sum_d[l*SUM_W +: SUM_W] = s1_sum_d[l*SUM_W +: SUM_W]
                    + SUM_W'(s_tdata[c*C_DATA_WIDTH + l*C_LANE_WIDTH +: C_LANE_WIDTH]);
            end
        end
    end

    // Stage-2 combinational: add constant, then wrap or clamp to lane width.
    always_comb begin
        s2_data_d = {C_DATA_WIDTH{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s[l] = s1_sum_q[l*SUM_W +: SUM_W] + SUM_W'(const_q);
            if (mode_q && (lane_sum_s[l][SUM_W-1:C_LANE_WIDTH] != {(SUM_W-C_LANE_WIDTH){1'b0}})) begin
                s2_data_d[l*C_LANE_WIDTH +: C_LANE_WIDTH] = {C_LANE_WIDTH{1'b1}};
            end else begin
                s2_data_d[l*C_LANE_WIDTH +: C_LANE_WIDTH] = lane_sum_s[l][C_LANE_WIDTH-1:0];
            end
        end
    end

    // Pipeline registers; both stages move together only when the output can advance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= {(LANES*SUM_W){1'b0}};
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= {C_DATA_WIDTH{1'b0}};
        end else if (adv_s) begin
            s1_valid_q <= accept_s;
            s1_last_q  <= accept_s && (in_rem_q == CNT_W'(1));
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule
